conv_kxk_engine: RTL and testbench

//  Parametrised successor to the fixed 3x3 convolution path. Holds an IMG_N x IMG_N image
//  and a KER_K x KER_K filter in internal register files and sequences every valid-window
//  MAC with its own FSM; no external mux addressing. Results are streamed out over a

---
 rtl/conv_kxk_engine.sv | 176 +++++++++++++++++
 tb/tb_conv_kxk_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_engine.sv
// KER_K x KER_K valid-window convolution engine with internal operand/result memories
// and a valid/ready result stream. Optional macro CONV_RELU_EN clamps negative results to 0.
module conv_kxk_engine #(
   parameter int DATA_W  = 8,
   parameter int IMG_N   = 4,
   parameter int KER_K   = 3,
   parameter int SHIFT   = 0,
   localparam int OUT_N   = IMG_N - KER_K + 1,
   localparam int OUT_CNT = OUT_N * OUT_N,
   localparam int AW      = (IMG_N * IMG_N > 1) ? $clog2(IMG_N * IMG_N) : 1,
   localparam int OW      = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              load_sel,
   input  logic [AW-1:0]     load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OW-1:0]     out_idx
);

   localparam int KK      = KER_K * KER_K;
   localparam int IMG_CNT = IMG_N * IMG_N;
   localparam int KW      = (KK > 1) ? $clog2(KK) : 1;
   localparam int CW      = $clog2(IMG_N + 1);
   localparam int ACC_W   = 2 * DATA_W + $clog2(KK) + 1;
   localparam int PW      = 2 * DATA_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN} state_t;

   state_t state;

   logic signed [DATA_W-1:0] img_mem [0:IMG_CNT-1];
   logic signed [DATA_W-1:0] ker_mem [0:KK-1];
   logic [DATA_W-1:0]        res_mem [0:OUT_CNT-1];

   logic [CW-1:0]           r, c, i, j;
   logic                    wr;
   logic signed [ACC_W-1:0] acc;

   logic [AW-1:0]           img_idx;
   logic [KW-1:0]           ker_idx;
   logic [OW-1:0]           res_idx;
   logic [OW-1:0]           idx_nxt;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] shifted;
   logic [DATA_W-1:0]       sat_val;

   always_comb begin
      img_idx  = AW'((32'(r) + 32'(i)) * 32'(IMG_N) + 32'(c) + 32'(j));
      ker_idx  = KW'(32'(i) * 32'(KER_K) + 32'(j));
      res_idx  = OW'(32'(r) * 32'(OUT_N) + 32'(c));
      idx_nxt  = out_idx + OW'(1);
      prod     = PW'(img_mem[img_idx]) * PW'(ker_mem[ker_idx]);
      prod_ext = ACC_W'(prod);
      shifted  = acc >>> SHIFT;
      if (shifted > SAT_MAX)
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shifted < SAT_MIN)
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_val = shifted[DATA_W-1:0];
`ifdef CONV_RELU_EN
      if (sat_val[DATA_W-1])
         sat_val = '0;
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         r         <= '0;
         c         <= '0;
         i         <= '0;
         j         <= '0;
         wr        <= 1'b0;
         acc       <= '0;
         for (int unsigned n = 0; n < IMG_CNT; n++) img_mem[AW'(n)] <= '0;
         for (int unsigned n = 0; n < KK; n++)      ker_mem[KW'(n)] <= '0;
         for (int unsigned n = 0; n < OUT_CNT; n++) res_mem[OW'(n)] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_en) begin
                  if (!load_sel) begin
                     if (32'(load_addr) < 32'(IMG_CNT))
                        img_mem[load_addr] <= load_data;
                  end else if (32'(load_addr) < 32'(KK)) begin
                     ker_mem[load_addr[KW-1:0]] <= load_data;
                  end
               end
               if (start) begin
                  state <= S_CALC;
                  busy  <= 1'b1;
                  r     <= '0;
                  c     <= '0;
                  i     <= '0;
                  j     <= '0;
                  wr    <= 1'b0;
                  acc   <= '0;
               end
            end

            S_CALC: begin
               if (!wr) begin
                  acc <= acc + prod_ext;
                  if (j == CW'(KER_K - 1)) begin
                     j <= '0;
                     if (i == CW'(KER_K - 1)) begin
                        i  <= '0;
                        wr <= 1'b1;
                     end else begin
                        i <= i + CW'(1);
                     end
                  end else begin
                     j <= j + CW'(1);
                  end
               end else begin
                  res_mem[res_idx] <= sat_val;
                  acc <= '0;
                  wr  <= 1'b0;
                  if (c == CW'(OUT_N - 1)) begin
                     c <= '0;
                     if (r == CW'(OUT_N - 1)) begin
                        r         <= '0;
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        // a single-output pass presents the value being written this edge
                        out_data  <= (OUT_CNT == 1) ? sat_val : res_mem[OW'(0)];
                     end else begin
                        r <= r + CW'(1);
                     end
                  end else begin
                     c <= c + CW'(1);
                  end
               end
            end

            S_DRAIN: begin
               if (out_ready) begin
                  if (out_idx == OW'(OUT_CNT - 1)) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     out_idx  <= idx_nxt;
                     out_data <= res_mem[idx_nxt];
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_kxk_engine.sv
// Directed self-checking bench: default 4x4/3x3 engine plus a 5x5/2x2 instance.
module tb_conv_kxk_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, load_en, load_sel, start, out_ready;
   logic [3:0] load_addr;
   logic [7:0] load_data, out_data;
   logic       busy, done, out_valid;
   logic [1:0] out_idx;

   logic       b_load_en, b_load_sel, b_start, b_out_ready;
   logic [4:0] b_load_addr;
   logic [7:0] b_load_data, b_out_data;
   logic       b_busy, b_done, b_out_valid;
   logic [3:0] b_out_idx;

   int vectors = 0;
   int errs    = 0;

   conv_kxk_engine dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
      .load_data(load_data), .start(start), .busy(busy), .done(done), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
   );

   conv_kxk_engine #(.DATA_W(8), .IMG_N(5), .KER_K(2), .SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .load_en(b_load_en), .load_sel(b_load_sel), .load_addr(b_load_addr),
      .load_data(b_load_data), .start(b_start), .busy(b_busy), .done(b_done),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_idx(b_out_idx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input logic sel, input int addr, input int data);
      load_en   = 1'b1;
      load_sel  = sel;
      load_addr = 4'(addr);
      load_data = 8'(data);
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic load_case1();
      for (int k = 0; k < 16; k++) load(1'b0, k, k + 1);
      for (int k = 0; k < 9; k++)  load(1'b1, k, 1);
   endtask

   task automatic start_wait(input string tag, output int lat);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 300) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic drain(input string tag, input int first, input logic [7:0] e [4]);
      out_ready = 1'b1;
      for (int n = first; n < 4; n++) begin
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_idx"}, out_idx, n);
         check({tag, "_data"}, out_data, e[n]);
         @(negedge clk);
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_valid_end"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   task automatic run(input string tag, input logic [7:0] e [4], input bit chk_lat);
      int lat;
      start_wait(tag, lat);
      if (chk_lat) check({tag, "_latency"}, lat, 40);
      drain(tag, 0, e);
   endtask

   initial begin
      logic [7:0] e_sum  [4] = '{8'd54, 8'd63, 8'd90, 8'd99};
      logic [7:0] e_ctr  [4] = '{8'd6, 8'd7, 8'd10, 8'd11};
      logic [7:0] e_pos  [4] = '{8'd127, 8'd127, 8'd127, 8'd127};
`ifdef CONV_RELU_EN
      logic [7:0] e_neg  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
`else
      logic [7:0] e_neg  [4] = '{8'h80, 8'h80, 8'h80, 8'h80};
`endif
      logic [7:0] e_zero [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
      int  lat;
      bit  saw_done;

      rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; out_ready = 1'b1;
      b_load_en = 1'b0; b_load_sel = 1'b0; b_load_addr = '0; b_load_data = '0;
      b_start = 1'b0; b_out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_idx", out_idx, 0);
      check("rst_b_idx", b_out_idx, 0);
      rst = 1'b0;
      @(negedge clk);

      // case 1: box filter, latency measured from the cycle busy rises
      load_case1();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("c1_busy_rise", busy, 1);
      check("c1_valid_low", out_valid, 0);
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check("c1_latency", lat, 40);
      drain("c1", 0, e_sum);

      // case 2: centre tap, then rerun without reload
      for (int k = 0; k < 9; k++) load(1'b1, k, (k == 4) ? 1 : 0);
      run("c2", e_ctr, 1'b1);
      run("c2_rerun", e_ctr, 1'b0);

      // case 3: saturation both directions
      for (int k = 0; k < 16; k++) load(1'b0, k, 127);
      for (int k = 0; k < 9; k++)  load(1'b1, k, 127);
      run("c3_pos", e_pos, 1'b0);
      for (int k = 0; k < 9; k++)  load(1'b1, k, -128);
      run("c3_neg", e_neg, 1'b0);

      // case 4: stall at idx1 with start/load pulses that must be ignored
      load_case1();
      out_ready = 1'b0;
      start_wait("c4", lat);
      check("c4_idx0", out_idx, 0);
      check("c4_data0", out_data, 54);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (n == 3) start = 1'b1;
         if (n == 5) begin
            load_en = 1'b1; load_sel = 1'b0; load_addr = 4'd0; load_data = 8'd99;
         end
         @(negedge clk);
         start = 1'b0;
         load_en = 1'b0;
         check("c4_stall_valid", out_valid, 1);
         check("c4_stall_idx", out_idx, 1);
         check("c4_stall_data", out_data, 63);
      end
      drain("c4", 1, e_sum);
      run("c4_mem_kept", e_sum, 1'b0);

      // case 5: reset mid-CALC aborts; memories cleared
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("c5_busy", busy, 0);
      check("c5_valid", out_valid, 0);
      saw_done = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
      end
      check("c5_no_done", saw_done, 0);
      run("c5_cleared", e_zero, 1'b0);
      load_case1();
      run("c5_reload", e_sum, 1'b1);

      // case 6: 5x5 image, 2x2 ones filter; output(r,c) = 20r + 4c + 16
      for (int k = 0; k < 29; k++) begin
         b_load_en   = 1'b1;
         b_load_sel  = (k >= 25);
         b_load_addr = 5'((k >= 25) ? k - 25 : k);
         b_load_data = 8'((k >= 25) ? 1 : k + 1);
         @(negedge clk);
      end
      b_load_en = 1'b0;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      check("c6_latency", lat, 80);
      for (int n = 0; n < 16; n++) begin
         check("c6_valid", b_out_valid, 1);
         check("c6_idx", b_out_idx, n);
         check("c6_data", b_out_data, 20 * (n / 4) + 4 * (n % 4) + 16);
         @(negedge clk);
      end
      check("c6_done", b_done, 1);
      check("c6_busy_end", b_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
